// File: rtl/est_state_correct_serial_pkg.sv
// Shared fixed-point definitions for the estimator measurement-update blocks.
package est_state_correct_serial_pkg;

  localparam int FXP_N    = 16;
  localparam int FXP_FRAC = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUB,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_M3
  } state_t;

  // Largest representable value of an n-bit signed word.
  function automatic logic signed [63:0] fxp_max(input int n);
    return (64'sd1 <<< (n - 1)) - 64'sd1;
  endfunction

  // Most negative value of an n-bit signed word.
  function automatic logic signed [63:0] fxp_min(input int n);
    return -(64'sd1 <<< (n - 1));
  endfunction

endpackage

// File: rtl/est_state_correct_serial_mul.sv
// Signed fixed-point multiply: full 2N-bit product shifted right arithmetically
// by FRAC, so the fractional bits are dropped toward -inf. Purely combinational.
module fxp_mul_trunc #(
  parameter int N    = 16,
  parameter int FRAC = 8
) (
  input  logic signed [N-1:0]   a,
  input  logic signed [N-1:0]   b,
  output logic signed [2*N-1:0] p
);

  logic signed [2*N-1:0] full;

  assign full = a * b;
  assign p    = full >>> FRAC;

endmodule

// File: rtl/est_state_correct_serial.sv
// Kalman measurement update: Y = z - zh, X = x + K*Y on 2x1 vectors with a 2x2
// gain, sharing one multiplier over a fixed SUB/M0/M1/M2/M3 schedule.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for start; operands latched on accept
// ST_SUB  | innovation Y0/Y1 = sat(z - zh)
// ST_M0   | acc = x00 + p(k00, Y0)
// ST_M1   | X00 = sat(acc + p(k01, Y1))
// ST_M2   | acc = x10 + p(k10, Y0)
// ST_M3   | X10 = sat(acc + p(k11, Y1)), pulse done
module est_state_correct_serial
  import est_state_correct_serial_pkg::*;
#(
  parameter int N    = FXP_N,
  parameter int FRAC = FXP_FRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] k00,
  input  logic [N-1:0] k01,
  input  logic [N-1:0] k10,
  input  logic [N-1:0] k11,
  input  logic [N-1:0] x00,
  input  logic [N-1:0] x10,
  input  logic [N-1:0] z00,
  input  logic [N-1:0] z10,
  input  logic [N-1:0] zh00,
  input  logic [N-1:0] zh10,
  output logic         done,
  output logic [N-1:0] Y00,
  output logic [N-1:0] Y10,
  output logic [N-1:0] X00,
  output logic [N-1:0] X10,
  output logic         sat
);

  // Wide enough for an (N+2)-bit acc plus a full 2N-bit product without overflow.
  localparam int W = 2 * N + 2;

  localparam logic signed [N-1:0] MAX_N   = N'(fxp_max(N));
  localparam logic signed [N-1:0] MIN_N   = N'(fxp_min(N));
  localparam logic signed [N:0]   SUB_MAX = (N + 1)'(fxp_max(N));
  localparam logic signed [N:0]   SUB_MIN = (N + 1)'(fxp_min(N));
  localparam logic signed [W-1:0] OUT_MAX = W'(fxp_max(N));
  localparam logic signed [W-1:0] OUT_MIN = W'(fxp_min(N));
  localparam logic signed [W-1:0] ACC_MAX = W'(fxp_max(N + 2));
  localparam logic signed [W-1:0] ACC_MIN = W'(fxp_min(N + 2));

  state_t state, state_nxt;
  logic   accept;

  logic signed [N-1:0]   r_k00, r_k01, r_k10, r_k11;
  logic signed [N-1:0]   r_x00, r_x10, r_z00, r_z10, r_zh00, r_zh10;
  logic signed [N+1:0]   acc;

  logic signed [N-1:0]   mul_a, mul_b;
  logic signed [2*N-1:0] prod;

  logic signed [N:0]     sub0, sub1;
  logic signed [N-1:0]   ysat0, ysat1;
  logic                  yclip0, yclip1;

  logic signed [W-1:0]   base_w, sum_w;
  logic signed [N-1:0]   out_sat;
  logic                  out_clip;
  logic signed [N+1:0]   acc_sat;
  logic                  acc_clip;

  fxp_mul_trunc #(.N(N), .FRAC(FRAC)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state sequencing and multiplier operand selection.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mul_a     = r_k00;
    mul_b     = Y00;
    unique case (state)
      ST_IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = ST_SUB;
      end
      ST_SUB:  state_nxt = ST_M0;
      ST_M0:   begin mul_a = r_k00; mul_b = Y00; state_nxt = ST_M1; end
      ST_M1:   begin mul_a = r_k01; mul_b = Y10; state_nxt = ST_M2; end
      ST_M2:   begin mul_a = r_k10; mul_b = Y00; state_nxt = ST_M3; end
      ST_M3:   begin mul_a = r_k11; mul_b = Y10; state_nxt = ST_IDLE; end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Innovation and accumulate arithmetic with clamp detection.
  always_comb begin
    sub0   = {r_z00[N-1], r_z00} - {r_zh00[N-1], r_zh00};
    sub1   = {r_z10[N-1], r_z10} - {r_zh10[N-1], r_zh10};
    yclip0 = (sub0 > SUB_MAX) || (sub0 < SUB_MIN);
    yclip1 = (sub1 > SUB_MAX) || (sub1 < SUB_MIN);
    ysat0  = (sub0 > SUB_MAX) ? MAX_N : (sub0 < SUB_MIN) ? MIN_N : sub0[N-1:0];
    ysat1  = (sub1 > SUB_MAX) ? MAX_N : (sub1 < SUB_MIN) ? MIN_N : sub1[N-1:0];

    // M0/M2 start from the prior state, M1/M3 continue from acc.
    base_w = W'(acc);
    if (state == ST_M0) base_w = W'(r_x00);
    if (state == ST_M2) base_w = W'(r_x10);
    sum_w  = base_w + W'(prod);

    out_clip = (sum_w > OUT_MAX) || (sum_w < OUT_MIN);
    out_sat  = (sum_w > OUT_MAX) ? MAX_N : (sum_w < OUT_MIN) ? MIN_N : sum_w[N-1:0];
    acc_clip = (sum_w > ACC_MAX) || (sum_w < ACC_MIN);
    acc_sat  = (sum_w > ACC_MAX) ? ACC_MAX[N+1:0] :
               (sum_w < ACC_MIN) ? ACC_MIN[N+1:0] : sum_w[N+1:0];
  end

  // Operand capture, accumulator, result registers and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k00 <= '0; r_k01 <= '0; r_k10 <= '0; r_k11 <= '0;
      r_x00 <= '0; r_x10 <= '0; r_z00 <= '0; r_z10 <= '0;
      r_zh00 <= '0; r_zh10 <= '0;
      acc  <= '0;
      Y00  <= '0; Y10 <= '0; X00 <= '0; X10 <= '0;
      sat  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (state == ST_M3);
      if (accept) begin
        r_k00  <= k00;  r_k01 <= k01;  r_k10 <= k10;  r_k11 <= k11;
        r_x00  <= x00;  r_x10 <= x10;  r_z00 <= z00;  r_z10 <= z10;
        r_zh00 <= zh00; r_zh10 <= zh10;
        sat    <= 1'b0;
      end
      unique case (state)
        ST_SUB: begin
          Y00 <= ysat0;
          Y10 <= ysat1;
          sat <= sat | yclip0 | yclip1;
        end
        ST_M0, ST_M2: begin
          acc <= acc_sat;
          sat <= sat | acc_clip;
        end
        ST_M1: begin
          X00 <= out_sat;
          sat <= sat | out_clip;
        end
        ST_M3: begin
          X10 <= out_sat;
          sat <= sat | out_clip;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_est_state_correct_serial.sv
// Scoreboard bench for est_state_correct_serial (N=16, FRAC=8, S=256).
module tb_est_state_correct_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] k00 = '0, k01 = '0, k10 = '0, k11 = '0;
  logic [15:0] x00 = '0, x10 = '0, z00 = '0, z10 = '0, zh00 = '0, zh10 = '0;
  logic        done, sat;
  logic [15:0] Y00, Y10, X00, X10;

  est_state_correct_serial dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .k00(k00), .k01(k01), .k10(k10), .k11(k11),
    .x00(x00), .x10(x10), .z00(z00), .z10(z10), .zh00(zh00), .zh10(zh10),
    .done(done), .Y00(Y00), .Y10(Y10), .X00(X00), .X10(X10), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y0, y1, x0, x1, s;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   last_done = -1;
  bit   spacing_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  // Monitor: every done pulse consumes one expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (spacing_chk && last_done >= 0) chk("done_spacing", cyc - last_done, 6);
      last_done = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("Y00", s16(Y00), e.y0);
        chk("Y10", s16(Y10), e.y1);
        chk("X00", s16(X00), e.x0);
        chk("X10", s16(X10), e.x1);
        chk("sat", int'(sat), e.s);
      end
    end
  end

  task automatic set_ops(input int a00, input int a01, input int a10, input int a11,
                         input int px0, input int px1, input int pz0, input int pz1,
                         input int ph0, input int ph1);
    k00 = 16'(a00); k01 = 16'(a01); k10 = 16'(a10); k11 = 16'(a11);
    x00 = 16'(px0); x10 = 16'(px1); z00 = 16'(pz0); z10 = 16'(pz1);
    zh00 = 16'(ph0); zh10 = 16'(ph1);
  endtask

  task automatic push_exp(input int y0, input int y1, input int px0, input int px1, input int s);
    exp_t e;
    e.y0 = y0; e.y1 = y1; e.x0 = px0; e.x1 = px1; e.s = s;
    exp_q.push_back(e);
  endtask

  // Returns just after the accepting edge E0.
  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic op_t1();
    set_ops(256, 0, 0, 256, 384, -192, 512, 64, 384, -192);
  endtask

  task automatic op_t2();
    set_ops(128, 64, 0, -256, 0, 0, 256, 512, 0, 0);
  endtask

  initial begin
    int ndone;
    // Reset values
    @(negedge clk);
    chk("rst_done", int'(done), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_Y00", s16(Y00), 0);
    chk("rst_X10", s16(X10), 0);
    @(negedge clk); rst_n = 1'b1;

    // 1: identity gain, latency check
    op_t1();
    push_exp(128, 256, 512, 64, 0);
    start_pulse();
    x00 = 16'd999; z00 = 16'd777;   // must not affect the accepted op
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 1) chk("Y00_after_E1", s16(Y00), 128);
      if (i == 4) chk("done_before_E5", int'(done), 0);
      if (i == 5) chk("done_after_E5", int'(done), 1);
    end
    wait_drain();

    // 2: general gain
    op_t2();
    push_exp(256, 512, 256, -512, 0);
    start_pulse();
    wait_drain();

    // 3: innovation saturation, then a clean op clears sat
    set_ops(0, 0, 0, 0, 0, 0, 32767, 0, -32768, 0);
    push_exp(32767, 0, 0, 0, 1);
    start_pulse();
    wait_drain();
    op_t1();
    push_exp(128, 256, 512, 64, 0);
    start_pulse();
    wait_drain();

    // 4: product truncation toward -inf
    set_ops(1, 0, 0, 0, 0, 0, -1, 0, 0, 0);
    push_exp(-1, 0, -1, 0, 0);
    start_pulse();
    wait_drain();
    set_ops(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    push_exp(1, 0, 0, 0, 0);
    start_pulse();
    wait_drain();

    // 5a: start while busy is ignored
    op_t2();
    push_exp(256, 512, 256, -512, 0);
    start_pulse();
    @(posedge clk); #1 start = 1'b1; op_t1();
    @(posedge clk); #1 start = 1'b0;
    wait_drain();
    repeat (8) @(negedge clk);

    // 5b: reset mid-op
    op_t1();
    start_pulse();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_done", int'(done), 0);
    chk("midrst_Y00", s16(Y00), 0);
    chk("midrst_X00", s16(X00), 0);
    chk("midrst_sat", int'(sat), 0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    chk("midrst_Y10_held", s16(Y10), 0);

    // 6: start held high, back-to-back ops every 6 cycles
    last_done = -1;
    spacing_chk = 1'b1;
    push_exp(128, 256, 512, 64, 0);
    push_exp(256, 512, 256, -512, 0);
    push_exp(-1, 0, -1, 0, 0);
    @(posedge clk); #1 op_t1(); start = 1'b1;
    @(posedge clk); #1 op_t2();
    repeat (6) @(posedge clk);
    #1 set_ops(1, 0, 0, 0, 0, 0, -1, 0, 0, 0);
    repeat (6) @(posedge clk);
    #1 start = 1'b0; set_ops(256, 0, 0, 256, 0, 0, 1000, 1000, 0, 0);
    wait_drain();
    repeat (10) @(negedge clk);
    spacing_chk = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
